fp_div_arbiter: RTL
===================

Name: fp_div_arbiter

Overview:
- Shares one pipelined FP32 divider (G_DIV: A, B in; C out; fixed latency, no stall, no valid) between two requesters.
- Arbitrates round-robin, registers the operands into the divider, and tags each issue in a shift pipe that matches the divider latency.
- Routes each quotient back to the requester that issued it.
- Supports a drain mode that blocks new issues until the divider pipe is empty. Sits between the two compute clients and the G_DIV instance.

Parameters:
- LAT, 12: G_DIV latency in clock edges, from the edge that updates A/B to the edge after which C holds that quotient.
- W, 32: operand and result width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_a  in  W  requester 0 dividend
- req0_b  in  W  requester 0 divisor
- req0_ready  out  1  requester 0 operation accepted this cycle
- req1_valid, req1_a, req1_b, req1_ready: same as requester 0, for requester 1
- div_a  out  W  registered dividend to G_DIV A
- div_b  out  W  registered divisor to G_DIV B
- div_c  in  W  G_DIV C
- res0_valid  out  1  one-cycle pulse: res0_data valid
- res0_data  out  W  quotient for requester 0
- res1_valid, res1_data: same, for requester 1
- drain  in  1  request quiesce
- drained  out  1  drain active and no operation in flight
- inflight  out  $clog2(LAT+2)  number of operations in flight

Behaviour:
Reset (rst=0 at an edge):
- div_a=div_b=0, res*_valid=0, res*_data=0, inflight=0, drained=0.
- Tag pipe cleared; round-robin pointer set so requester 0 wins the first tie; FSM goes to RUN.
- Operations in flight when reset is taken are discarded: no res*_valid for them after reset, even though G_DIV still emits quotients.

Grant:
- Combinational grant; reqX_ready = grant to X.
- Accept occurs when reqX_valid & reqX_ready.
- At most one grant per cycle; no grants in DRAIN.
- Only one requester valid: that requester is granted.
- Both valid: grant the one not granted most recently; the pointer updates only on a grant.
- reqX_ready is never high while reqX_valid is low.

Issue:
- On the accept edge k, div_a/div_b load the granted a/b, and tag {valid=1, id=X} enters the tag pipe (depth LAT+1).
- With no accept, div_a/div_b hold their values and a tag with valid=0 enters the pipe.

Return:
- The tag emerges at edge k+LAT+1. At that edge div_c is registered into resX_data, and resX_valid is 1 for exactly one cycle.
- Accept-to-result latency is LAT+1 edges.
- Throughput is one operation per cycle.
- There is no result backpressure; the requester must consume the pulse.
- res_data for the non-returning requester holds its previous value.

inflight:
- +1 on accept, -1 on return.
- Both in the same cycle: no change.
- Maximum value LAT+1.

FSM:
- RUN -> DRAIN when drain=1.
- DRAIN: no grants. drained = (inflight==0), registered.
- DRAIN -> RUN when drain=0; drained clears in the same edge.
- If drain is asserted in the same cycle as a pending request, that request is not granted.

Widths and arithmetic:
- No FP arithmetic in the block; quotients pass through bit-exact.
- Special values (NaN, Inf, zero divisor) are not inspected.

Test Plan:
- Reset, req0 only, a=0x40000000, b=0x3F800000 -> req0_ready=1 in that cycle; res0_valid pulse exactly LAT+1 edges later with res0_data=0x40000000; res1_valid stays 0.
- req0 and req1 both valid for 4 cycles: req0 0x42000000/0x40000000, req1 0x3FC00000/0x3E000000 -> grants alternate 0,1,0,1; results alternate 0x41800000 (res0) and 0x41400000 (res1) on consecutive cycles.
- Back-to-back issues from req1 for LAT+1 cycles -> inflight reaches LAT+1; then one result returns per cycle, in issue order.
- Issue 3 operations, assert drain, keep req0_valid=1 -> no further req0_ready; drained rises one cycle after the third result; deassert drain -> req0 is granted on the next cycle.
- Issue 5 operations, pulse rst=0 for one cycle mid-flight -> no res*_valid afterwards; inflight=0; first grant after reset goes to req0 when both requesters are valid.
- Accept and return in the same cycle -> inflight unchanged; check that the round-robin pointer is unchanged in a cycle with no grant.

Source files
------------

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: shares one fixed-latency FP32 divider between two requesters.
// Round-robin grant, registered operands, and a tag pipe matching the divider
// latency that steers each quotient back to the requester that issued it.
module fp_div_arbiter #(
  parameter int LAT = 12,
  parameter int W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  input  logic [W-1:0]             req0_a,
  input  logic [W-1:0]             req0_b,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [W-1:0]             req1_a,
  input  logic [W-1:0]             req1_b,
  output logic                     req1_ready,
  output logic [W-1:0]             div_a,
  output logic [W-1:0]             div_b,
  input  logic [W-1:0]             div_c,
  output logic                     res0_valid,
  output logic [W-1:0]             res0_data,
  output logic                     res1_valid,
  output logic [W-1:0]             res1_data,
  input  logic                     drain,
  output logic                     drained,
  output logic [$clog2(LAT+2)-1:0] inflight
);
  localparam int CW = $clog2(LAT+2);

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;        // requester granted most recently
  logic [LAT:0]  tag_vld_q, tag_vld_d;  // slot holds a live operation
  logic [LAT:0]  tag_id_q, tag_id_d;    // owner of that operation
  logic [W-1:0]  div_a_q, div_a_d;
  logic [W-1:0]  div_b_q, div_b_d;
  logic          res0_valid_q, res0_valid_d;
  logic          res1_valid_q, res1_valid_d;
  logic [W-1:0]  res0_data_q, res0_data_d;
  logic [W-1:0]  res1_data_q, res1_data_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          drained_q, drained_d;
  logic          gnt0, gnt1;
  logic          accept, retire;

  // Round-robin grant; nothing is granted while draining or while drain is being raised.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == ST_RUN && !drain) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign accept = gnt0 | gnt1;
  assign retire = tag_vld_q[LAT];

  // Next-state: operand capture, tag shift, result steering, in-flight count, drain FSM.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    res0_data_d  = res0_data_q;
    res1_data_d  = res1_data_q;
    inflight_d   = inflight_q;
    tag_vld_d    = {tag_vld_q[LAT-1:0], accept};
    tag_id_d     = {tag_id_q[LAT-1:0], gnt1};
    res0_valid_d = retire && !tag_id_q[LAT];
    res1_valid_d = retire && tag_id_q[LAT];
    drained_d    = (state_q == ST_DRAIN) && drain && (inflight_q == '0);

    if (accept) begin
      div_a_d = gnt1 ? req1_a : req0_a;
      div_b_d = gnt1 ? req1_b : req0_b;
      last_d  = gnt1;
    end

    if (res0_valid_d) res0_data_d = div_c;
    if (res1_valid_d) res1_data_d = div_c;

    case ({accept, retire})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    case (state_q)
      ST_RUN:   if (drain)  state_d = ST_DRAIN;
      ST_DRAIN: if (!drain) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // State registers; reset empties the tag pipe so in-flight quotients are dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      last_q       <= 1'b1;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      res0_valid_q <= 1'b0;
      res1_valid_q <= 1'b0;
      res0_data_q  <= '0;
      res1_data_q  <= '0;
      inflight_q   <= '0;
      drained_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      res0_valid_q <= res0_valid_d;
      res1_valid_q <= res1_valid_d;
      res0_data_q  <= res0_data_d;
      res1_data_q  <= res1_data_d;
      inflight_q   <= inflight_d;
      drained_q    <= drained_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign res0_valid = res0_valid_q;
  assign res1_valid = res1_valid_q;
  assign res0_data  = res0_data_q;
  assign res1_data  = res1_data_q;
  assign inflight   = inflight_q;
  assign drained    = drained_q;

endmodule
